// File: rtl/npu_tile_sched_pkg.sv
// Shared geometry for the NPU tile scheduler: per-layer tile limits, derived index
// widths and the scheduler state encoding.
package npu_tile_sched_pkg;

   localparam int W  = 8;
   localparam int K  = 5;
   localparam int KK = K * K;

   localparam int C1_NB_TILE  = 4;
   localparam int C1_NB_TILEB = 1;
   localparam int C1_NB_TILEC = 6;

   localparam int C2_NB_TILE  = 2;
   localparam int C2_NB_TILEB = 6;
   localparam int C2_NB_TILEC = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int NB_TILE  = max_int(C1_NB_TILE, C2_NB_TILE);
   localparam int NB_TILEB = max_int(C1_NB_TILEB, C2_NB_TILEB);
   localparam int NB_TILEC = max_int(C1_NB_TILEC, C2_NB_TILEC);

   localparam int CLOG2T  = $clog2(NB_TILE);
   localparam int CLOG2B  = $clog2(NB_TILEB);
   localparam int CLOG2C  = $clog2(NB_TILEC);
   localparam int CLOG2K  = $clog2(K);
   // Activation span is the larger of the two layers' (nt*nt*nb) footprints.
   localparam int CLOG2M  = $clog2(max_int(C1_NB_TILE * C1_NB_TILE * C1_NB_TILEB,
                                           C2_NB_TILE * C2_NB_TILE * C2_NB_TILEB));
   localparam int CLOG2MW = $clog2(NB_TILEC * KK);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WB   = 2'd2,
      ST_DONE = 2'd3
   } sched_state_e;

endpackage

// File: rtl/npu_tile_sched_cnt.sv
// Wrapping up-counter: counts to the terminal value on limit, then returns to zero.
module npu_wrap_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             last
);

   assign last = (cnt == limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= last ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/npu_tile_sched.sv
// Tile scheduler: walks tile_ch > tile_r > tile_c > tile_b > k_idx for the
// selected conv layer, offering MAC steps and one write-back per output tile.
//
//  state   | meaning
//  IDLE    | waiting for start; layer latched and counters zeroed on start
//  RUN     | offering MAC steps, inner counters advance on handshake
//  WB      | output tile finished, waiting for write-back acceptance
//  DONE    | one-cycle completion pulse
module npu_tile_sched
   import npu_tile_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  layer_sel,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  step_valid,
   input  logic                  step_ready,
   output logic                  acc_clr,
   output logic [CLOG2K*2-1:0]   k_idx,
   output logic [CLOG2T-1:0]     tile_r,
   output logic [CLOG2T-1:0]     tile_c,
   output logic [CLOG2B-1:0]     tile_b,
   output logic [CLOG2C-1:0]     tile_ch,
   output logic [CLOG2MW-1:0]    w_addr,
   output logic [CLOG2M-1:0]     a_addr,
   output logic                  wb_valid,
   input  logic                  wb_ready
);

   localparam int KW = CLOG2K * 2;

   sched_state_e state_q, state_d;
   logic         layer_q;

   logic [KW-1:0]     k_lim;
   logic [CLOG2T-1:0] t_lim;
   logic [CLOG2B-1:0] b_lim;
   logic [CLOG2C-1:0] ch_lim;
   logic [CLOG2M-1:0] nt, nb;

   logic k_last, b_last, c_last, r_last, ch_last, last_tile;
   logic hs, wb_fire, cnt_clr;
   logic en_k, en_b, en_c, en_r, en_ch;

   // Counter limits are terminal values (layer count minus one).
   assign k_lim  = KW'(KK - 1);
   assign t_lim  = layer_q ? CLOG2T'(C2_NB_TILE - 1)  : CLOG2T'(C1_NB_TILE - 1);
   assign b_lim  = layer_q ? CLOG2B'(C2_NB_TILEB - 1) : CLOG2B'(C1_NB_TILEB - 1);
   assign ch_lim = layer_q ? CLOG2C'(C2_NB_TILEC - 1) : CLOG2C'(C1_NB_TILEC - 1);
   assign nt     = layer_q ? CLOG2M'(C2_NB_TILE)  : CLOG2M'(C1_NB_TILE);
   assign nb     = layer_q ? CLOG2M'(C2_NB_TILEB) : CLOG2M'(C1_NB_TILEB);

   assign hs        = (state_q == ST_RUN) && step_ready;
   assign wb_fire   = (state_q == ST_WB) && wb_ready;
   assign last_tile = c_last && r_last && ch_last;
   assign cnt_clr   = abort || (state_q == ST_DONE) || ((state_q == ST_IDLE) && start);

   // k and b wrap together on the tile's final step, so WB sees them at zero.
   assign en_k  = hs;
   assign en_b  = hs && k_last;
   assign en_c  = wb_fire && !last_tile;
   assign en_r  = en_c && c_last;
   assign en_ch = en_r && r_last;

   npu_wrap_cnt #(.WIDTH(KW)) u_cnt_k (
      .clk(clk), .rst(rst), .en(en_k), .clr(cnt_clr), .limit(k_lim),
      .cnt(k_idx), .last(k_last));

   npu_wrap_cnt #(.WIDTH(CLOG2B)) u_cnt_b (
      .clk(clk), .rst(rst), .en(en_b), .clr(cnt_clr), .limit(b_lim),
      .cnt(tile_b), .last(b_last));

   npu_wrap_cnt #(.WIDTH(CLOG2T)) u_cnt_c (
      .clk(clk), .rst(rst), .en(en_c), .clr(cnt_clr), .limit(t_lim),
      .cnt(tile_c), .last(c_last));

   npu_wrap_cnt #(.WIDTH(CLOG2T)) u_cnt_r (
      .clk(clk), .rst(rst), .en(en_r), .clr(cnt_clr), .limit(t_lim),
      .cnt(tile_r), .last(r_last));

   npu_wrap_cnt #(.WIDTH(CLOG2C)) u_cnt_ch (
      .clk(clk), .rst(rst), .en(en_ch), .clr(cnt_clr), .limit(ch_lim),
      .cnt(tile_ch), .last(ch_last));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         layer_q <= 1'b0;
      else if ((state_q == ST_IDLE) && start && !abort)
         layer_q <= layer_sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      busy       = (state_q != ST_IDLE);
      step_valid = (state_q == ST_RUN);
      wb_valid   = (state_q == ST_WB);
      done       = (state_q == ST_DONE);
      acc_clr    = (state_q == ST_RUN) && (tile_b == '0) && (k_idx == '0);
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (hs && k_last && b_last) state_d = ST_WB;
         ST_WB:   if (wb_ready) state_d = last_tile ? ST_DONE : ST_RUN;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort)
         state_d = ST_IDLE;
   end

   assign w_addr = CLOG2MW'(tile_ch) * CLOG2MW'(KK) + CLOG2MW'(k_idx);
   assign a_addr = (CLOG2M'(tile_r) * nt + CLOG2M'(tile_c)) * nb + CLOG2M'(tile_b);

endmodule

// File: tb/tb_npu_tile_sched.sv
// Bench for npu_tile_sched: loop-nest reference queue checked on every step
// handshake, a table of full-layer runs, and hand sequences for stall/abort/reset.
module tb_npu_tile_sched;
   import npu_tile_sched_pkg::*;

   logic clk = 1'b0;
   logic rst, start, layer_sel, abort, step_ready, wb_ready;
   logic busy, done, step_valid, acc_clr, wb_valid;
   logic [CLOG2K*2-1:0] k_idx;
   logic [CLOG2T-1:0]   tile_r, tile_c;
   logic [CLOG2B-1:0]   tile_b;
   logic [CLOG2C-1:0]   tile_ch;
   logic [CLOG2MW-1:0]  w_addr;
   logic [CLOG2M-1:0]   a_addr;

   always #5 clk = ~clk;

   npu_tile_sched dut (
      .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel), .abort(abort),
      .busy(busy), .done(done), .step_valid(step_valid), .step_ready(step_ready),
      .acc_clr(acc_clr), .k_idx(k_idx), .tile_r(tile_r), .tile_c(tile_c),
      .tile_b(tile_b), .tile_ch(tile_ch), .w_addr(w_addr), .a_addr(a_addr),
      .wb_valid(wb_valid), .wb_ready(wb_ready));

   typedef struct packed {
      logic [CLOG2K*2-1:0] k;
      logic [CLOG2B-1:0]   b;
      logic [CLOG2T-1:0]   r;
      logic [CLOG2T-1:0]   c;
      logic [CLOG2C-1:0]   ch;
      logic [CLOG2MW-1:0]  w;
      logic [CLOG2M-1:0]   a;
      logic                acc;
   } step_t;

   typedef struct {
      logic layer;
      int   sr_rand;
      int   wr_rand;
      int   exp_hs;
      int   exp_wb;
      int   exp_wb_cyc;
      int   exp_max_w;
   } vec_t;

   step_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    n_hs, n_wb, n_wb_cyc, n_done, max_w;
   logic  prev_stall = 1'b0;
   step_t prev_step;
   vec_t  vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic step_t cur_step();
      step_t s;
      s.k = k_idx; s.b = tile_b; s.r = tile_r; s.c = tile_c; s.ch = tile_ch;
      s.w = w_addr; s.a = a_addr; s.acc = acc_clr;
      return s;
   endfunction

   task automatic push_layer(input logic l);
      int nt, nb, nc;
      step_t s;
      nt = l ? C2_NB_TILE  : C1_NB_TILE;
      nb = l ? C2_NB_TILEB : C1_NB_TILEB;
      nc = l ? C2_NB_TILEC : C1_NB_TILEC;
      for (int ch = 0; ch < nc; ch++)
         for (int r = 0; r < nt; r++)
            for (int c = 0; c < nt; c++)
               for (int b = 0; b < nb; b++)
                  for (int k = 0; k < 25; k++) begin
                     s.k   = (CLOG2K*2)'(k);
                     s.b   = CLOG2B'(b);
                     s.r   = CLOG2T'(r);
                     s.c   = CLOG2T'(c);
                     s.ch  = CLOG2C'(ch);
                     s.w   = CLOG2MW'(ch * 25 + k);
                     s.a   = CLOG2M'((r * nt + c) * nb + b);
                     s.acc = (b == 0) && (k == 0);
                     exp_q.push_back(s);
                  end
   endtask

   task automatic reset_counts();
      n_hs = 0; n_wb = 0; n_wb_cyc = 0; n_done = 0; max_w = 0;
   endtask

   task automatic monitor();
      step_t s;
      s = cur_step();
      if (step_valid && prev_stall)
         check("stall_hold", 64'(s), 64'(prev_step));
      if (step_valid && step_ready) begin
         n_hs++;
         if (int'(s.w) > max_w) max_w = int'(s.w);
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL step_extra actual=%0h required=none", s);
         end else
            check("step_seq", 64'(s), 64'(exp_q.pop_front()));
      end
      if (wb_valid) n_wb_cyc++;
      if (wb_valid && wb_ready) n_wb++;
      if (done) n_done++;
      prev_stall = step_valid && !step_ready;
      prev_step  = s;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic start_layer(input logic l);
      exp_q.delete();
      push_layer(l);
      reset_counts();
      layer_sel = l;
      start = 1'b1;
      run_cycle();
      start = 1'b0;
   endtask

   task automatic run_and_check(input vec_t v);
      start_layer(v.layer);
      for (int i = 0; i < 40000 && n_done == 0; i++) begin
         step_ready = (v.sr_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         wb_ready   = (v.wr_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         run_cycle();
      end
      if (n_done == 0) begin
         checks++; errors++;
         $display("FAIL run_timeout actual=no_done required=done layer=%0d", v.layer);
      end
      run_cycle();
      check("run_handshakes", 64'(n_hs), 64'(v.exp_hs));
      check("run_wb_count", 64'(n_wb), 64'(v.exp_wb));
      if (v.exp_wb_cyc >= 0) check("run_wb_cycles", 64'(n_wb_cyc), 64'(v.exp_wb_cyc));
      check("run_done_pulses", 64'(n_done), 64'd1);
      check("run_max_w_addr", 64'(max_w), 64'(v.exp_max_w));
      check("run_queue_left", 64'(exp_q.size()), 64'd0);
      check("run_idle_after", 64'(busy), 64'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 0, 0, 2400, 96, 96, 149};
      vecs[1] = '{1'b1, 0, 0, 9600, 64, 64, 399};
      vecs[2] = '{1'b0, 1, 0, 2400, 96, 96, 149};
      vecs[3] = '{1'b1, 1, 1, 9600, 64, -1, 399};

      rst = 1'b1; start = 1'b0; layer_sel = 1'b0; abort = 1'b0;
      step_ready = 1'b0; wb_ready = 1'b0;
      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_step_valid", 64'(step_valid), 64'd0);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_acc_clr", 64'(acc_clr), 64'd0);
      check("rst_indices", 64'(cur_step()), 64'd0);
      @(posedge clk); #1;
      run_cycle();
      rst = 1'b0;
      run_cycle();

      for (int v = 0; v < 4; v++)
         run_and_check(vecs[v]);

      // Write-back held off for 10 cycles on the first conv1 tile.
      start_layer(1'b0);
      step_ready = 1'b1; wb_ready = 1'b0;
      for (int i = 0; i < 100 && !wb_valid; i++) run_cycle();
      check("wbstall_reached", 64'(wb_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         run_cycle();
         check("wbstall_hold", 64'({wb_valid, step_valid}), 64'(2'b10));
      end
      wb_ready = 1'b1;
      run_cycle();
      check("wbstall_resume", 64'(step_valid), 64'd1);
      check("wbstall_tile_c", 64'(tile_c), 64'd1);
      check("wbstall_outer", 64'({tile_r, tile_ch}), 64'd0);
      abort = 1'b1; step_ready = 1'b0;
      run_cycle();
      abort = 1'b0;

      // Abort after 37 handshakes, with a handshake offered in the same cycle.
      start_layer(1'b1);
      step_ready = 1'b1; wb_ready = 1'b1;
      for (int i = 0; i < 200 && n_hs < 37; i++) run_cycle();
      check("abort_at_37", 64'(n_hs), 64'd37);
      abort = 1'b1;
      run_cycle();
      abort = 1'b0; step_ready = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_step_valid", 64'(step_valid), 64'd0);
      run_cycle();
      check("abort_no_done", 64'(n_done), 64'd0);
      run_and_check(vecs[0]);

      // start ignored while busy, then reset asserted in the middle of WB.
      start_layer(1'b0);
      step_ready = 1'b1; wb_ready = 1'b0;
      for (int i = 0; i < 5; i++) run_cycle();
      layer_sel = 1'b1; start = 1'b1;
      run_cycle();
      start = 1'b0;
      check("busy_start_ignored", 64'(busy), 64'd1);
      for (int i = 0; i < 100 && !wb_valid; i++) run_cycle();
      check("rstwb_reached", 64'(wb_valid), 64'd1);
      check("rstwb_hs_count", 64'(n_hs), 64'd25);
      rst = 1'b1;
      #1;
      check("rstwb_ctrl_zero", 64'({busy, done, step_valid, acc_clr, wb_valid}), 64'd0);
      check("rstwb_index_zero", 64'(cur_step()), 64'd0);
      run_cycle();
      rst = 1'b0; wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) run_cycle();
      check("rstwb_no_done", 64'(n_done), 64'd0);
      check("rstwb_idle", 64'({busy, wb_valid}), 64'd0);
      exp_q.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/npu_tile_sched.md
NPU_TILE_SCHED -- requirements
Module: npu_tile_sched

Interface
REQ-001 SHALL have no parameters of its own; all sizes come from the shared globals package: W, K, KK, C1_NB_TILE/B/C, C2_NB_TILE/B/C, NB_TILE/B/C, CLOG2T/B/C/K, CLOG2M, CLOG2MW.
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request a layer run; honoured only in IDLE.
REQ-006 layer_sel  in  1  0 = conv1 geometry, 1 = conv2 geometry; sampled with start.
REQ-007 abort  in  1  synchronous cancel of a run.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at normal run completion.
REQ-010 step_valid  out  1  MAC step offered to the datapath.
REQ-011 step_ready  in  1  datapath accepts the step.
REQ-012 acc_clr  out  1  high with the first step (b=0, k=0) of each output tile.
REQ-013 k_idx  out  CLOG2K*2  kernel position, 0..KK-1.
REQ-014 tile_r, tile_c  out  CLOG2T each  spatial tile row/column.
REQ-015 tile_b  out  CLOG2B  input-channel tile.
REQ-016 tile_ch  out  CLOG2C  output-channel tile.
REQ-017 w_addr  out  CLOG2MW  weight address = tile_ch*KK + k_idx.
REQ-018 a_addr  out  CLOG2M  activation address = (tile_r*nt + tile_c)*nb + tile_b, where nt/nb are the selected layer's NB_TILE/NB_TILEB.
REQ-019 wb_valid  out  1  write-back request for the finished output tile.
REQ-020 wb_ready  in  1  write-back accepted.

Function
REQ-021 SHALL implement states IDLE, RUN, WB, DONE.
REQ-022 IDLE: start=1 latches layer geometry and zeroes all counters; RUN is entered the next cycle.
REQ-023 RUN: step_valid=1; counters advance only on step_valid&&step_ready; outputs are held stable while stalled.
REQ-024 Loop nest, outer to inner: tile_ch, tile_r, tile_c, tile_b, k_idx; each counter wraps to 0 after its layer limit minus 1.
REQ-025 A handshake with k_idx=KK-1 and tile_b=nb-1 SHALL move the block to WB; spatial and channel indices are not advanced.
REQ-026 WB: wb_valid=1, step_valid=0, tile indices held.
REQ-027 WB exit on wb_ready: if last tile (all outer counters at limit) go to DONE, else advance the outer counters and return to RUN.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 start SHALL be ignored when busy=1.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge with no done pulse; abort has priority over every handshake in the same cycle.
REQ-031 w_addr and a_addr SHALL be combinational from the registered counters, with zero-extension and no truncation for both geometries.

Reset
REQ-032 rst=1 SHALL force IDLE and zero all counters and the layer register at once.
REQ-033 During reset, all outputs SHALL be 0 (busy, done, step_valid, acc_clr, wb_valid, and all indices/addresses).
REQ-034 Reset mid-run SHALL discard the run, with no done and no wb_valid.

Structure
REQ-035 The state enum typedef and the per-layer limit constants (C*_NB_TILE/B/C, KK) SHALL live in the shared globals package.
REQ-036 The five counters SHALL each be an instance of one sub-module, npu_wrap_cnt: parameterised width, enable, clear, limit input, and a last/wrap output.

Verification
REQ-037 conv1, step_ready=wb_ready=1: exactly 2400 step handshakes, 96 wb_valid cycles, and one done pulse.
REQ-038 conv2, step_ready=wb_ready=1: exactly 9600 step handshakes, 64 WBs, and the maximum w_addr seen is 399.
REQ-039 step_ready toggled randomly: indices and addresses stay stable while stalled, and the sequence matches a reference loop-nest model.
REQ-040 wb_ready held low for 10 cycles: wb_valid stays high, step_valid stays 0, and RUN resumes with tile_c incremented.
REQ-041 abort in RUN at step 37: busy=0 next cycle, no done; a subsequent start runs cleanly from zero.
REQ-042 start pulsed during RUN and rst asserted mid-WB: start is ignored; rst takes all outputs to 0 immediately.
